// File: rtl/daq_intr_gen.sv
// daq_intr_gen: counts packet words, queues packet lengths and raises a held
// interrupt per packet until the MCU acknowledges, then enforces a low gap.
module daq_intr_gen #(
  parameter int PKT_WORDS = 1024,
  parameter int CNT_W     = 16,
  parameter int MIN_HIGH  = 4,
  parameter int MIN_LOW   = 4,
  parameter int MAX_PEND  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             frame_start,
  input  logic             rd_ack,
  output logic             intr_out,
  output logic [3:0]       pend_cnt,
  output logic [CNT_W-1:0] pkt_len,
  output logic             ovf
);
  localparam logic [1:0] IDLE = 2'd0, ASSERT = 2'd1, WAIT_ACK = 2'd2, GAP = 2'd3;
  localparam int PTR_W   = MAX_PEND > 1 ? $clog2(MAX_PEND) : 1;
  localparam int TMR_MAX = MIN_HIGH > MIN_LOW ? MIN_HIGH : MIN_LOW;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic             r_ack_s1, r_ack_s2, r_ack_s3, r_ack_lat;
  logic [CNT_W-1:0] r_word_cnt, r_len;
  logic [CNT_W-1:0] r_mem [MAX_PEND];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [3:0]       r_pend;
  logic [1:0]       r_state;
  logic [TMR_W-1:0] r_tmr;
  logic             r_intr, r_ovf;
  logic             w_wrap, w_flush, w_enq, w_push, w_ack_ev, w_ack_any;
  logic             w_hi_done, w_lo_done, w_deq;
  logic [CNT_W-1:0] w_inc, w_enq_len;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return p == PTR_W'(MAX_PEND - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inc     = {{(CNT_W-1){1'b0}}, wr_en};
    w_wrap    = r_word_cnt == CNT_W'(PKT_WORDS - 1);
    w_flush   = frame_start && r_word_cnt != '0;
    w_enq     = w_flush || (wr_en && w_wrap);
    w_enq_len = w_flush ? r_word_cnt + w_inc : CNT_W'(PKT_WORDS);
    w_push    = w_enq && r_pend != 4'(MAX_PEND);
    w_ack_ev  = r_ack_s2 && !r_ack_s3;
    w_ack_any = w_ack_ev || r_ack_lat;
    w_hi_done = r_tmr == TMR_W'(MIN_HIGH - 1);
    w_lo_done = r_tmr == TMR_W'(MIN_LOW - 1);
    w_deq     = w_ack_any && (r_state == WAIT_ACK || (r_state == ASSERT && w_hi_done));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_s1   <= 1'b0;
      r_ack_s2   <= 1'b0;
      r_ack_s3   <= 1'b0;
      r_word_cnt <= '0;
      r_ovf      <= 1'b0;
      r_pend     <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
    end else begin
      r_ack_s1   <= rd_ack;
      r_ack_s2   <= r_ack_s1;
      r_ack_s3   <= r_ack_s2;
      r_word_cnt <= w_enq ? '0 : r_word_cnt + w_inc;
      r_ovf      <= r_ovf || (w_enq && !w_push);
      r_pend     <= r_pend + 4'(w_push) - 4'(w_deq);
      r_wr       <= w_push ? nxt(r_wr) : r_wr;
      r_rd       <= w_deq ? nxt(r_rd) : r_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_enq_len;
  end

  // A full MIN_HIGH window with an ack already latched drops straight into GAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tmr     <= '0;
      r_ack_lat <= 1'b0;
      r_intr    <= 1'b0;
      r_len     <= '0;
    end else begin
      case (r_state)
        IDLE: if (r_pend != '0) begin
          r_state <= ASSERT;
          r_intr  <= 1'b1;
          r_tmr   <= '0;
          r_len   <= r_mem[r_rd];
        end
        ASSERT: begin
          r_tmr     <= w_hi_done ? '0 : r_tmr + 1'b1;
          r_ack_lat <= w_ack_any && !w_hi_done;
          if (w_hi_done) begin
            r_state <= w_ack_any ? GAP : WAIT_ACK;
            r_intr  <= !w_ack_any;
          end
        end
        WAIT_ACK: if (w_ack_any) begin
          r_state <= GAP;
          r_intr  <= 1'b0;
          r_tmr   <= '0;
        end
        GAP: begin
          r_tmr   <= r_tmr + 1'b1;
          r_state <= w_lo_done ? IDLE : GAP;
        end
      endcase
    end
  end

  assign intr_out = r_intr;
  assign pend_cnt = r_pend;
  assign pkt_len  = r_len;
  assign ovf      = r_ovf;
endmodule
